// File: rtl/pattern_serializer.sv
// Parallel-to-serial pattern transmitter, MSB-first, one bit per step edge.
// Ports: clk, reset (async, active-high), step (async level), start, abort,
//   repeat_en, load_data[WIDTH], load_len[LEN_W] in; x_out, busy, done,
//   err, remaining[LEN_W] out.
module pattern_serializer #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             step,
    input  logic             start,
    input  logic             abort,
    input  logic             repeat_en,
    input  logic [WIDTH-1:0] load_data,
    input  logic [LEN_W-1:0] load_len,
    output logic             x_out,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [LEN_W-1:0] remaining
);

    localparam logic [LEN_W-1:0] WIDTH_L = LEN_W'(WIDTH);
    localparam logic [LEN_W-1:0] ONE_L   = LEN_W'(1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t             state_q, state_d;
    logic               s1_q, s2_q, s3_q;
    logic [WIDTH-1:0]   pat_q, pat_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               rep_q, rep_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic               x_q, x_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               step_edge;
    logic               len_ok;
    logic [LEN_W-1:0]   shamt;
    logic [WIDTH-1:0]   aligned;
    logic [WIDTH-1:0]   shifted;

    assign step_edge = s2_q & ~s3_q;
    assign len_ok    = (load_len != '0) && (load_len <= WIDTH_L);
    assign shamt     = WIDTH_L - load_len;
    // Left-align so the first bit to send always sits at the MSB.
    assign aligned   = load_data << shamt;
    assign shifted   = shreg_q << 1;

    // Synchronizer resets high: a step held through reset gives no edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
            s3_q <= 1'b1;
        end else begin
            s1_q <= step;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pat_q   <= '0;
            shreg_q <= '0;
            len_q   <= '0;
            rep_q   <= 1'b0;
            rem_q   <= '0;
            x_q     <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            shreg_q <= shreg_d;
            len_q   <= len_d;
            rep_q   <= rep_d;
            rem_q   <= rem_d;
            x_q     <= x_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        shreg_d = shreg_q;
        len_d   = len_q;
        rep_d   = rep_q;
        rem_d   = rem_q;
        x_d     = x_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                x_d   = 1'b0;
                rem_d = '0;
                if (start) begin
                    if (len_ok) begin
                        pat_d   = aligned;
                        shreg_d = aligned;
                        len_d   = load_len;
                        rep_d   = repeat_en;
                        rem_d   = load_len;
                        x_d     = aligned[WIDTH-1];
                        state_d = SEND;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            SEND: begin
                if (abort) begin
                    state_d = IDLE;
                    x_d     = 1'b0;
                    rem_d   = '0;
                end else if (step_edge) begin
                    // Test for the last bit before decrementing.
                    if (rem_q == ONE_L) begin
                        if (rep_q) begin
                            shreg_d = pat_q;
                            rem_d   = len_q;
                            x_d     = pat_q[WIDTH-1];
                        end else begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                            x_d     = 1'b0;
                            rem_d   = '0;
                        end
                    end else begin
                        shreg_d = shifted;
                        rem_d   = rem_q - ONE_L;
                        x_d     = shifted[WIDTH-1];
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        busy = (state_q == SEND);
    end

    assign x_out     = x_q;
    assign done      = done_q;
    assign err       = err_q;
    assign remaining = rem_q;

endmodule

// File: tb/tb_pattern_serializer.sv
// Scoreboard bench for pattern_serializer: stimulus pushes expected
// output events, a negedge monitor pops and compares them.
module tb_pattern_serializer;

    typedef struct packed {
        logic       b;
        logic       x;
        logic [3:0] r;
        logic       d;
        logic       e;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       step = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       repeat_en = 1'b0;
    logic [7:0] load_data = '0;
    logic [3:0] load_len = '0;
    logic       x_out, busy, done, err;
    logic [3:0] remaining;

    int  checks = 0;
    int  errors = 0;
    ev_t q[$];
    logic [5:0] prev = '0;

    pattern_serializer #(.WIDTH(8), .LEN_W(4)) dut (
        .clk(clk), .reset(reset), .step(step), .start(start),
        .abort(abort), .repeat_en(repeat_en), .load_data(load_data),
        .load_len(load_len), .x_out(x_out), .busy(busy), .done(done),
        .err(err), .remaining(remaining)
    );

    always #5 clk = ~clk;

    // Monitor: an output event is any change of busy/x/remaining,
    // or any cycle with done or err high.
    always @(negedge clk) begin : monitor
        ev_t got;
        ev_t exp;
        logic [5:0] snap;
        snap = {busy, x_out, remaining};
        if (snap != prev || done || err) begin
            got = '{b: busy, x: x_out, r: remaining, d: done, e: err};
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event @%0t: got b=%0b x=%0b rem=%0d done=%0b err=%0b, required no event",
                         $time, got.b, got.x, got.r, got.d, got.e);
            end else begin
                exp = q.pop_front();
                if (got !== exp) begin
                    errors++;
                    $display("FAIL event @%0t: got b=%0b x=%0b rem=%0d done=%0b err=%0b, required b=%0b x=%0b rem=%0d done=%0b err=%0b",
                             $time, got.b, got.x, got.r, got.d, got.e,
                             exp.b, exp.x, exp.r, exp.d, exp.e);
                end
            end
        end
        prev = snap;
    end

    task automatic push(input logic b, input logic x, input logic [3:0] r,
                        input logic d, input logic e);
        ev_t ev;
        ev = '{b: b, x: x, r: r, d: d, e: e};
        q.push_back(ev);
    endtask

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0d, required %0d", n, $time, act, exp);
        end
    endtask

    task automatic do_start(input logic [7:0] d, input logic [3:0] l,
                            input logic r);
        @(negedge clk);
        load_data = d;
        load_len  = l;
        repeat_en = r;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic step_pulse();
        @(negedge clk);
        step = 1'b1;
        repeat (4) @(negedge clk);
        step = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic do_abort();
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    logic xr[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    int   rr[7] = '{2, 1, 3, 2, 1, 3, 2};

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_x", 32'(x_out), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_rem", 32'(remaining), 0);
        chk("reset_done_err", 32'({done, err}), 0);
        reset = 1'b0;

        // One-shot, 6 bits of 0010_1011 -> 1,0,1,0,1,1
        push(1, 1, 6, 0, 0);
        do_start(8'b0010_1011, 4'd6, 1'b0);
        push(1, 0, 5, 0, 0); step_pulse();
        push(1, 1, 4, 0, 0); step_pulse();
        push(1, 0, 3, 0, 0); step_pulse();
        push(1, 1, 2, 0, 0); step_pulse();
        push(1, 1, 1, 0, 0); step_pulse();
        push(0, 0, 0, 1, 0); step_pulse();
        repeat (3) @(negedge clk);
        chk("oneshot_idle_busy", 32'(busy), 0);
        chk("oneshot_idle_x", 32'(x_out), 0);

        // Repeat mode, 3'b011 -> 0,1,1,0,1,1,0,1
        push(1, 0, 3, 0, 0);
        do_start(8'h03, 4'd3, 1'b1);
        for (int i = 0; i < 7; i++) begin
            push(1, xr[i], 4'(rr[i]), 0, 0);
            step_pulse();
        end
        chk("repeat_busy", 32'(busy), 1);
        push(0, 0, 0, 0, 0);
        do_abort();
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);

        // Synchronizer latency: advance on the 3rd posedge only
        push(1, 0, 4, 0, 0);
        do_start(8'h05, 4'd4, 1'b0);
        push(1, 1, 3, 0, 0);
        @(negedge clk); step = 1'b1;
        @(negedge clk); chk("lat_edge1_rem", 32'(remaining), 4);
        @(negedge clk); chk("lat_edge2_rem", 32'(remaining), 4);
        @(negedge clk); chk("lat_edge3_rem", 32'(remaining), 3);
        chk("lat_edge3_x", 32'(x_out), 1);
        repeat (17) @(negedge clk);
        step = 1'b0;
        repeat (4) @(negedge clk);
        chk("hold_one_bit_rem", 32'(remaining), 3);
        push(0, 0, 0, 0, 0);
        do_abort();

        // Step held high across reset release gives no edge
        @(negedge clk); step = 1'b1;
        @(negedge clk); reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        push(1, 0, 4, 0, 0);
        load_data = 8'h05; load_len = 4'd4; repeat_en = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (6) @(negedge clk);
        chk("step_thru_reset_rem", 32'(remaining), 4);
        step = 1'b0;
        repeat (3) @(negedge clk);
        push(0, 0, 0, 0, 0);
        do_abort();

        // Illegal lengths
        push(0, 0, 0, 0, 1);
        do_start(8'hAA, 4'd0, 1'b0);
        chk("len0_busy", 32'(busy), 0);
        repeat (2) @(negedge clk);
        push(0, 0, 0, 0, 1);
        do_start(8'hFF, 4'd9, 1'b0);
        chk("len9_busy", 32'(busy), 0);
        repeat (2) @(negedge clk);

        // Start during SEND is ignored
        push(1, 1, 5, 0, 0);
        do_start(8'b0001_0110, 4'd5, 1'b0);
        do_start(8'hFF, 4'd3, 1'b0);
        repeat (2) @(negedge clk);
        chk("ignored_start_rem", 32'(remaining), 5);
        push(1, 0, 4, 0, 0);
        step_pulse();

        // Async reset with remaining=4
        push(0, 0, 0, 0, 0);
        @(posedge clk); #3 reset = 1'b1;
        #1;
        chk("async_reset_x", 32'(x_out), 0);
        chk("async_reset_busy", 32'(busy), 0);
        chk("async_reset_rem", 32'(remaining), 0);
        @(negedge clk);
        @(negedge clk); reset = 1'b0;

        // Two-bit pattern 2'b10 after reset
        push(1, 1, 2, 0, 0);
        do_start(8'b0000_0010, 4'd2, 1'b0);
        push(1, 0, 1, 0, 0); step_pulse();
        push(0, 0, 0, 1, 0); step_pulse();

        // Abort coincident with a step edge: no done
        push(1, 1, 3, 0, 0);
        do_start(8'b0000_0101, 4'd3, 1'b0);
        push(0, 0, 0, 0, 0);
        @(negedge clk); step = 1'b1;
        @(negedge clk);
        @(negedge clk); abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        chk("abort_edge_busy", 32'(busy), 0);
        chk("abort_edge_done", 32'(done), 0);
        repeat (3) @(negedge clk);
        step = 1'b0;

        repeat (5) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL missing_events: got %0d pending, required 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pattern_serializer.md
Name: pattern_serializer

Overview:
- Parallel-to-serial bit-stream transmitter. Produces the serial `x` stimulus that the shift-register sequence-detector lab consumes.
- Loads a pattern word of programmable length and presents it MSB-first on `x_out`, one bit per step.
- Steps come from a debounced key level or a slow strobe; the block synchronizes and edge-detects them internally.
- Supports one-shot and repeat modes, abort, and busy/done/err status.

Parameters:
- WIDTH, 8: maximum pattern length in bits.
- LEN_W, 4: width of length/remaining fields. Must satisfy 2^LEN_W > WIDTH.

Ports:
- clk  input  1  system clock.
- reset  input  1  reset, asynchronous, active-high; clock clk.
- step  input  1  asynchronous step level (debounced key). Each rising edge advances one bit.
- start  input  1  single-cycle request to load and begin sending.
- abort  input  1  single-cycle request to stop and return to idle.
- repeat_en  input  1  sampled at start. When 1, the pattern loops indefinitely.
- load_data  input  WIDTH  pattern. Bits [load_len-1:0] are sent, bit load_len-1 first.
- load_len  input  LEN_W  number of bits to send; legal range 1..WIDTH.
- x_out  output  1  current serial bit.
- busy  output  1  high in SEND.
- done  output  1  one-cycle pulse when a one-shot pattern completes.
- err  output  1  one-cycle pulse when start carries an illegal length.
- remaining  output  LEN_W  bits still to be consumed, including the current one.

Behaviour:
- Reset values (asynchronous):
  - state=IDLE, x_out=0, busy=0, done=0, err=0, remaining=0.
  - Pattern and shift registers cleared.
  - Synchronizer flops s1, s2, s3 are set to 1, so a step held high through reset release produces no edge.
- Step path:
  - s1<=step, s2<=s1, s3<=s2.
  - step_edge = s2 & ~s3, combinational.
  - x_out/remaining update on the 3rd rising clk edge after step rises, with setup met.
  - A downstream receiver clocked directly by step therefore samples a stable x_out.
- State IDLE:
  - x_out=0, busy=0.
  - start with load_len in 1..WIDTH:
    - pat <= load_data left-aligned, i.e. shift left by WIDTH-load_len.
    - len_q <= load_len, rep_q <= repeat_en, shreg <= aligned pattern, remaining <= load_len.
    - Go to SEND.
  - start with load_len=0 or >WIDTH: err=1 for one cycle, stay IDLE.
  - step edges in IDLE are discarded.
- State SEND:
  - busy=1, x_out=shreg[WIDTH-1]. x_out is registered: it changes in the same cycle as shreg.
  - On step_edge with remaining>1: shreg <= shreg<<1 (zero fill), remaining-1.
  - On step_edge with remaining==1 and rep_q=1: shreg <= pat, remaining <= len_q. No done pulse; stay in SEND.
  - On step_edge with remaining==1 and rep_q=0: go to IDLE, done=1 for one cycle, x_out=0, remaining=0.
  - start while in SEND: ignored, no err.
  - abort: IDLE next cycle, no done, x_out=0, remaining=0.
- Priority in the same cycle:
  - abort > step_edge.
  - In IDLE, start is acted on and a coincident edge is dropped.
  - done and err are never both asserted.
- Reset mid-SEND: immediate return to reset values. The pattern is lost.
- Widths:
  - remaining is never 0 in SEND.
  - The counter must not wrap. The remaining==1 check precedes the decrement.

Test Plan:
- Bit order: load_data=8'b0010_1011, load_len=6, repeat_en=0, start, then 6 step pulses.
  - x_out sequence must be 1,0,1,0,1,1.
  - remaining must count 6→1.
  - Exactly one done pulse after the 6th edge, then busy=0 and x_out=0.
  - A detector fed by this stream sees its target pattern.
- Repeat mode: load_data=8'h03, load_len=3, repeat_en=1, 7 step pulses.
  - x_out must be 0,1,1,0,1,1,0,1.
  - No done pulse; busy stays 1.
  - abort then gives busy=0 the next cycle with no done.
- Synchronizer latency: raise step once with the block in SEND.
  - x_out/remaining change exactly on the 3rd clk edge.
  - Holding step high for 20 cycles advances exactly one bit.
  - step high across reset release produces no advance.
- Illegal/ignored starts:
  - load_len=0 → err pulse, busy=0.
  - load_len=9 with WIDTH=8 → err pulse.
  - A legal start during SEND is ignored: pattern and remaining are unchanged, no err.
- Simultaneity and reset:
  - abort and a step edge in the same cycle → IDLE with no done.
  - Asynchronous reset asserted with remaining=4 → all outputs 0 immediately.
  - A subsequent start with len=2 and data 2'b10 sends 1,0 correctly.
